// File: rtl/char_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module      : char_sprite_renderer
// Description : Composites the player character sprite over the background
//               VGA pixel stream. Character position, facing and physics
//               state are sampled once per frame (at frame_start) into shadow
//               registers, mapped from y-up physics coordinates to raster
//               coordinates, and used to address an external synchronous
//               sprite ROM. Texels equal to the TRANSPARENT key show the
//               background.
//
// Optional feature macro:
//   CHAR_HITBOX_EN - when defined, every in-box pixel on the first/last
//                    sprite row or column is forced to HITBOX_COLOR
//                    (overrides ROM data and the transparency key).
//
// Ports:
//   vga_clk      in   pixel clock (only clock)
//   sys_rst      in   synchronous active-high reset
//   h_cnt/v_cnt  in   current raster column / row
//   video_on     in   raster is inside the active area
//   frame_start  in   one-cycle pulse during vertical blank
//   char_pos_x   in   signed physics x (+x = screen-left)
//   char_pos_y   in   signed physics y (+y = screen-up)
//   char_face    in   2'b01 left, 2'b11 right, 2'b00 none (drawn as left)
//   char_state   in   physics FSM state
//   bg_pixel     in   background colour for the current h_cnt/v_cnt
//   rom_addr     out  {sprite_sel, row, col}; 0 outside the sprite box
//   rom_data     in   ROM texel, valid one cycle after rom_addr
//   pixel_out    out  composited pixel, 3 cycles after h_cnt/v_cnt
//
// Revision    : 1.0 - initial release
// ============================================================================
module char_sprite_renderer #(
  parameter int                     PHY_WIDTH    = 10,
  parameter int                     PIXEL_WIDTH  = 12,
  parameter int                     CHAR_WIDTH_X = 32,
  parameter int                     CHAR_WIDTH_Y = 32,
  parameter int                     H_ACTIVE     = 640,
  parameter int                     V_ACTIVE     = 480,
  parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT  = 12'hF0F,
  parameter int                     ANIM_FRAMES  = 8,
  parameter logic [PIXEL_WIDTH-1:0] HITBOX_COLOR = 12'h0F0
) (
  input  logic                          vga_clk,
  input  logic                          sys_rst,
  input  logic [9:0]                    h_cnt,
  input  logic [9:0]                    v_cnt,
  input  logic                          video_on,
  input  logic                          frame_start,
  input  logic signed [PHY_WIDTH:0]     char_pos_x,
  input  logic signed [PHY_WIDTH:0]     char_pos_y,
  input  logic [1:0]                    char_face,
  input  logic [3:0]                    char_state,
  input  logic [PIXEL_WIDTH-1:0]        bg_pixel,
  output logic [2+$clog2(CHAR_WIDTH_Y)+$clog2(CHAR_WIDTH_X)-1:0] rom_addr,
  input  logic [PIXEL_WIDTH-1:0]        rom_data,
  output logic [PIXEL_WIDTH-1:0]        pixel_out
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int C_COL_W  = $clog2(CHAR_WIDTH_X);
  localparam int C_ROW_W  = $clog2(CHAR_WIDTH_Y);
  localparam int C_ADDR_W = 2 + C_ROW_W + C_COL_W;
  // Coordinate arithmetic width: wide enough that H_ACTIVE - pos - size
  // never wraps for any representable physics position.
  localparam int C_CW     = PHY_WIDTH + 3;
  localparam int C_ANIM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  localparam logic signed [C_CW-1:0] C_H_ACT = C_CW'(H_ACTIVE);
  localparam logic signed [C_CW-1:0] C_V_ACT = C_CW'(V_ACTIVE);
  localparam logic signed [C_CW-1:0] C_CWX   = C_CW'(CHAR_WIDTH_X);
  localparam logic signed [C_CW-1:0] C_CWY   = C_CW'(CHAR_WIDTH_Y);
  localparam logic [C_ANIM_W-1:0]    C_ANIM_LAST = C_ANIM_W'(ANIM_FRAMES - 1);

  localparam logic [1:0] C_FACE_RIGHT = 2'b11;

  // --------------------------------------------------------------------------
  // Per-frame shadow registers and walk animation
  // --------------------------------------------------------------------------
  logic signed [PHY_WIDTH:0] r_sh_x;
  logic signed [PHY_WIDTH:0] r_sh_y;
  logic [1:0]                r_sh_face;
  logic [3:0]                r_sh_state;
  logic                      r_sh_valid;
  logic [C_ANIM_W-1:0]       r_anim_cnt;
  logic                      r_walk_phase;

  logic w_walk_state;
  assign w_walk_state = (char_state == 4'd1) || (char_state == 4'd2);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_sh_x       <= '0;
      r_sh_y       <= '0;
      r_sh_face    <= '0;
      r_sh_state   <= '0;
      r_sh_valid   <= 1'b0;
      r_anim_cnt   <= '0;
      r_walk_phase <= 1'b0;
    end else if (frame_start) begin
      r_sh_x     <= char_pos_x;
      r_sh_y     <= char_pos_y;
      r_sh_face  <= char_face;
      r_sh_state <= char_state;
      r_sh_valid <= 1'b1;
      // The animation advances on the state being latched this frame, so
      // the phase and the shadowed state always change together.
      if (w_walk_state) begin
        if (r_anim_cnt == C_ANIM_LAST) begin
          r_anim_cnt   <= '0;
          r_walk_phase <= ~r_walk_phase;
        end else begin
          r_anim_cnt <= r_anim_cnt + 1'b1;
        end
      end else begin
        r_anim_cnt   <= '0;
        r_walk_phase <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Physics -> raster coordinate map (signed, non-wrapping)
  // --------------------------------------------------------------------------
  logic signed [C_CW-1:0] w_px;
  logic signed [C_CW-1:0] w_py;
  logic signed [C_CW-1:0] w_h;
  logic signed [C_CW-1:0] w_v;
  logic signed [C_CW-1:0] w_scr_x0;
  logic signed [C_CW-1:0] w_scr_y0;
  logic signed [C_CW-1:0] w_dx;
  logic signed [C_CW-1:0] w_dy;
  logic                   w_in_x;
  logic                   w_in_y;
  logic                   w_in_box;

  assign w_px = {{2{r_sh_x[PHY_WIDTH]}}, r_sh_x};
  assign w_py = {{2{r_sh_y[PHY_WIDTH]}}, r_sh_y};
  assign w_h  = {{(C_CW-10){1'b0}}, h_cnt};
  assign w_v  = {{(C_CW-10){1'b0}}, v_cnt};

  // Physics x grows to the left and y grows upward, hence the subtractions.
  assign w_scr_x0 = C_H_ACT - w_px - C_CWX;
  assign w_scr_y0 = C_V_ACT - w_py - C_CWY;

  // Local offsets into the sprite; in range iff 0 <= d < size. Using the
  // offsets avoids a second adder for scr_x0 + size.
  assign w_dx = w_h - w_scr_x0;
  assign w_dy = w_v - w_scr_y0;

  assign w_in_x   = !w_dx[C_CW-1] && (w_dx < C_CWX);
  assign w_in_y   = !w_dy[C_CW-1] && (w_dy < C_CWY);
  assign w_in_box = r_sh_valid && video_on && w_in_x && w_in_y;

  // --------------------------------------------------------------------------
  // Sprite texel address
  // --------------------------------------------------------------------------
  logic [C_ROW_W-1:0] w_row;
  logic [C_COL_W-1:0] w_col_raw;
  logic [C_COL_W-1:0] w_col;
  logic [1:0]         w_sel;
  logic [C_ADDR_W-1:0] w_addr;

  assign w_row     = w_dy[C_ROW_W-1:0];
  assign w_col_raw = w_dx[C_COL_W-1:0];
  // Art faces left; right-facing mirrors the column. With a power-of-two
  // width, CHAR_WIDTH_X-1-col is simply the bitwise complement.
  assign w_col     = (r_sh_face == C_FACE_RIGHT) ? ~w_col_raw : w_col_raw;

  always_comb begin
    w_sel = 2'd0;
    case (r_sh_state)
      4'd3:             w_sel = 2'd1;
      4'd4, 4'd5, 4'd6: w_sel = 2'd2;
      4'd1, 4'd2:       w_sel = r_walk_phase ? 2'd3 : 2'd0;
      default:          w_sel = 2'd0;
    endcase
  end

  assign w_addr = w_in_box ? {w_sel, w_row, w_col} : '0;

  // --------------------------------------------------------------------------
  // Pipeline: stage 1 registers the address and side-band, stage 2 waits for
  // the ROM, stage 3 composites.
  // --------------------------------------------------------------------------
  logic                   r_inbox1;
  logic                   r_von1;
  logic [PIXEL_WIDTH-1:0] r_bg1;
  logic                   r_inbox2;
  logic                   r_von2;
  logic [PIXEL_WIDTH-1:0] r_bg2;

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      rom_addr <= '0;
      r_inbox1 <= 1'b0;
      r_von1   <= 1'b0;
      r_bg1    <= '0;
      r_inbox2 <= 1'b0;
      r_von2   <= 1'b0;
      r_bg2    <= '0;
    end else begin
      rom_addr <= w_addr;
      r_inbox1 <= w_in_box;
      r_von1   <= video_on;
      r_bg1    <= bg_pixel;
      r_inbox2 <= r_inbox1;
      r_von2   <= r_von1;
      r_bg2    <= r_bg1;
    end
  end

`ifdef CHAR_HITBOX_EN
  // Outline flag travels alongside the address so it lines up with rom_data.
  logic w_edge;
  logic r_edge1;
  logic r_edge2;

  assign w_edge = (w_row == '0) || (w_row == '1) ||
                  (w_col_raw == '0) || (w_col_raw == '1);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_edge1 <= 1'b0;
      r_edge2 <= 1'b0;
    end else begin
      r_edge1 <= w_edge;
      r_edge2 <= r_edge1;
    end
  end
`endif

  logic [PIXEL_WIDTH-1:0] w_pix_next;

  always_comb begin
    w_pix_next = r_bg2;
    if (!r_von2) begin
      w_pix_next = '0;
    end else if (r_inbox2 && (rom_data != TRANSPARENT)) begin
      w_pix_next = rom_data;
    end
`ifdef CHAR_HITBOX_EN
    if (r_von2 && r_inbox2 && r_edge2) begin
      w_pix_next = HITBOX_COLOR;
    end
`endif
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      pixel_out <= '0;
    end else begin
      pixel_out <= w_pix_next;
    end
  end

endmodule
`default_nettype wire
